// File: rtl/imm_rotate_encoder_pkg.sv
// Shared definitions for the immediate-operand rotate encoder: FSM states,
// operand field positions, the result record and a rotate helper.
package imm_rotate_encoder_pkg;

    // Search controller states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEARCH     = 2'd1,
        ST_SEARCH_INV = 2'd2,
        ST_FINISH     = 2'd3
    } state_e;

    // Opcode class of data-processing instructions with an immediate operand.
    localparam logic [2:0] OPC_CLASS_IMM = 3'b001;

    // Operand field positions inside IR[11:0].
    localparam int ROT_MSB = 11;
    localparam int ROT_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Highest rotate field value; the search ends after testing it.
    localparam logic [3:0] ROT_LAST = 4'd15;

    // Registered search outcome presented to the instruction builder.
    typedef struct packed {
        logic       valid;
        logic       inverted;
        logic [3:0] rot4;
        logic [7:0] imm8;
        logic       carry;
    } result_t;

    // True when an opcode class selects the rotated-immediate operand form.
    function automatic logic is_imm_class(input logic [2:0] opc_class);
        return opc_class == OPC_CLASS_IMM;
    endfunction

    // Rotate left by 0..31; the upper half of the doubled word is the result.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} << amt;
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle between the instruction builder and the encoder.
interface imm_rotate_encoder_if;

    logic        start;
    logic [31:0] value;
    logic        cin;
    logic        busy;
    logic        done;
    logic        valid;
    logic        inverted;
    logic [7:0]  imm8;
    logic [3:0]  rot4;
    logic [11:0] encoding;
    logic        carry_out;

    modport master (
        output start, value, cin,
        input  busy, done, valid, inverted, imm8, rot4, encoding, carry_out
    );

    modport slave (
        input  start, value, cin,
        output busy, done, valid, inverted, imm8, rot4, encoding, carry_out
    );

endinterface

// File: rtl/imm_rotate_encoder_rot_fit_check.sv
// Combinational test of one candidate rotation: the target fits when rotating
// it left by 2*rot leaves only the low byte populated; that byte is imm8.
module imm_rotate_encoder_rot_fit_check
    import imm_rotate_encoder_pkg::*;
(
    input  logic [31:0] tgt_i,
    input  logic [3:0]  rot_i,
    output logic        fit_o,
    output logic [7:0]  imm8_o
);

    logic [31:0] rolled;

    // 2*rot is formed on 5 bits, so 0..30 never overflows.
    assign rolled = rol32(tgt_i, {rot_i, 1'b0});
    assign fit_o  = (rolled[31:8] == 24'd0);
    assign imm8_o = rolled[7:0];

endmodule

// File: rtl/imm_rotate_encoder.sv
// Finds the canonical {rot4, imm8} encoding of a 32-bit constant by testing one
// rotation per clock, smallest first, optionally retrying on the inverted
// constant. Results are registered and change only when a search finishes.
module imm_rotate_encoder
    import imm_rotate_encoder_pkg::*;
#(
    parameter bit TRY_INVERT = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    imm_rotate_encoder_if.slave  bus
);

    state_e      state_q;
    logic [31:0] tgt_q;
    logic [3:0]  rot_q;
    logic        cin_q;
    logic        busy_q;
    logic        done_q;
    result_t     res_q;

    logic        fit;
    logic [7:0]  fit_imm8;
    result_t     hit_res;

    imm_rotate_encoder_rot_fit_check u_fit (
        .tgt_i  (tgt_q),
        .rot_i  (rot_q),
        .fit_o  (fit),
        .imm8_o (fit_imm8)
    );

    // Result to register if the rotation under test fits.
    // NOTE: every field gets a default first so this block can never infer a latch.
    always_comb begin
        hit_res          = '0;
        hit_res.valid    = 1'b1;
        hit_res.inverted = (state_q == ST_SEARCH_INV);
        hit_res.rot4     = rot_q;
        hit_res.imm8     = fit_imm8;
        // A nonzero rotation makes the shifter carry the decoded bit 31, which
        // equals bit 31 of the (possibly inverted) target; rot 0 passes CIN.
        hit_res.carry    = (rot_q != 4'd0) ? tgt_q[31] : cin_q;
    end

    // Search controller, rotation counter and registered results.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            rot_q   <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        tgt_q   <= bus.value;
                        cin_q   <= bus.cin;
                        rot_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEARCH;
                    end
                end
                ST_SEARCH, ST_SEARCH_INV: begin
                    if (fit) begin
                        res_q   <= hit_res;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (rot_q != ROT_LAST) begin
                        rot_q <= rot_q + 4'd1;
                    end else if (TRY_INVERT && state_q == ST_SEARCH) begin
                        // Direct form exhausted: retry as MVN/BIC on ~value.
                        tgt_q   <= ~tgt_q;
                        rot_q   <= '0;
                        state_q <= ST_SEARCH_INV;
                    end else begin
                        res_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    // A start request here is deliberately not sampled.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy                      = busy_q;
    assign bus.done                      = done_q;
    assign bus.valid                     = res_q.valid;
    assign bus.inverted                  = res_q.inverted;
    assign bus.imm8                      = res_q.imm8;
    assign bus.rot4                      = res_q.rot4;
    assign bus.encoding[ROT_MSB:ROT_LSB] = res_q.rot4;
    assign bus.encoding[IMM_MSB:IMM_LSB] = res_q.imm8;
    assign bus.carry_out                 = res_q.carry;

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
Reverse of the data-processing shifter's 32-bit immediate path. The shifter expands an instruction's {rot4, imm8} field into ROR(imm8, 2*rot4). This block takes an arbitrary 32-bit constant and searches, one rotation per clock, for the canonical {rot4, imm8} encoding, falling back to the bitwise-inverted constant (MVN/BIC form) when enabled. It sits beside the instruction-build and verification logic and feeds 12-bit operand fields into IR[11:0].

Parameters:
TRY_INVERT, 1, 1 = search ~VALUE after the direct search fails; 0 = direct search only.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  request; sampled only in IDLE.
VALUE  input  32  constant to encode; latched when START is accepted.
CIN  input  1  current carry flag; used for CARRY_OUT when rot = 0.
BUSY  output  1  high while a search is in progress.
DONE  output  1  one-cycle pulse when results are valid.
VALID  output  1  an encoding was found.
INVERTED  output  1  the encoding applies to ~VALUE.
IMM8  output  8  encoded immediate.
ROT4  output  4  rotate field; rotation = 2*ROT4.
ENCODING  output  12  {ROT4, IMM8}.
CARRY_OUT  output  1  shifter carry that decoding this encoding produces.

Behaviour:
- Reset (async, any state): state=IDLE. BUSY, DONE, VALID, INVERTED, IMM8, ROT4, ENCODING and CARRY_OUT all 0. Any search in progress is abandoned with no DONE.
- States and transitions:
  - IDLE: on START, latch VALUE into tgt, set rot=0, go to SEARCH.
  - SEARCH: each cycle test ROL(tgt, 2*rot)[31:8] == 0.
    - Hit: go to FINISH with the result.
    - Miss with rot=15: go to SEARCH_INV with tgt=~tgt and rot=0 if TRY_INVERT, else go to FINISH with VALID=0.
    - Miss otherwise: rot++.
  - SEARCH_INV: same test on the inverted target. Hit sets INVERTED=1. Miss at rot=15 goes to FINISH with VALID=0.
  - FINISH: DONE=1 for exactly this one cycle, then IDLE.
- Counting from the cycle START is sampled (cycle 0):
  - Cycle n+1 tests rot n (n = 0..15).
  - A hit at rot k asserts DONE in cycle k+2.
  - Inverted rot k is tested in cycle 17+k; a hit there asserts DONE in cycle 18+k.
  - Direct-only failure asserts DONE in cycle 17; full failure asserts DONE in cycle 33.
- The smallest rot wins, which gives the canonical encoding. VALUE=0 encodes as rot0/imm0.
- BUSY is high from the cycle after START through the last search cycle; it is low in FINISH.
- START is ignored while not in IDLE. A START in the FINISH cycle is also ignored.
- Result outputs are registered and update only on entry to FINISH. They hold until the next FINISH.
- On failure: VALID=0, INVERTED=0, IMM8=0, ROT4=0.
- ENCODING is always {ROT4, IMM8}.
- CARRY_OUT = bit31 of the encoded target (VALUE, or ~VALUE when INVERTED) if ROT4 != 0, else CIN sampled at START.
- CARRY_OUT is 0 when VALID=0.
- ROL width: rotation amount is 2*rot, 0..30, computed on 5 bits with no overflow.

Decomposition:
- Shared constants in the existing ARM definitions package:
  - state encodings IDLE/SEARCH/SEARCH_INV/FINISH (2 bits);
  - the immediate-operand opcode class 3'b001;
  - field positions ROT=[11:8], IMM=[7:0].
- One natural sub-module, rot_fit_check. It is combinational: given (tgt, rot) it returns fit and imm8.
- The FSM, counter and result registers live in the top block.

Test Plan:
- VALUE=0x000000FF, CIN=0: expect DONE in cycle 2, VALID=1, INVERTED=0, IMM8=0xFF, ROT4=0, ENCODING=0x0FF, CARRY_OUT=0.
- VALUE=0xFF000000 and VALUE=0xF000000F:
  - 0xFF000000: expect ROT4=4, IMM8=0xFF, CARRY_OUT=1, DONE in cycle 6.
  - 0xF000000F: expect ROT4=2, IMM8=0xFF, CARRY_OUT=1, DONE in cycle 4.
- VALUE=0x00000104: expect ROT4=15, IMM8=0x41, ENCODING=0xF41, DONE in cycle 17, CARRY_OUT=0.
- VALUE=0xFFFFFF00, TRY_INVERT=1: expect VALID=1, INVERTED=1, IMM8=0xFF, ROT4=0, CARRY_OUT=CIN, DONE in cycle 18.
- VALUE=0x00000102:
  - TRY_INVERT=1: expect VALID=0, DONE in cycle 33, all fields 0.
  - TRY_INVERT=0: expect VALID=0, DONE in cycle 17.
- Reset and protocol edge cases:
  - Assert RESET in cycle 5 of a search for 0x00000104: expect outputs 0 immediately and no DONE.
  - START pulsed while BUSY: expect it ignored.
  - Back-to-back START asserted in the FINISH cycle: expect it ignored; a START one cycle later is accepted.
